// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ writeback sources.
// Optional write-to-read forwarding on rd1/rd2 is enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int unsigned n    = 16,
    parameter int unsigned r    = 4,
    parameter int unsigned NREQ = 2,
    parameter int unsigned CW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*r-1:0] req_addr,
    input  logic [NREQ*n-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              we3,
    output logic [r-1:0]      wa3,
    output logic [n-1:0]      wd3,
    input  logic [r-1:0]      ra1,
    input  logic [r-1:0]      ra2,
    input  logic [n-1:0]      rf_rd1,
    input  logic [n-1:0]      rf_rd2,
    output logic [n-1:0]      rd1,
    output logic [n-1:0]      rd2,
    output logic [CW-1:0]     conflict_cnt
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_ptr;
    logic            r_we3;
    logic [r-1:0]    r_wa3;
    logic [n-1:0]    r_wd3;
    logic [CW-1:0]   r_cnt;

    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_gidx;
    logic [PW-1:0]   w_scan_idx;
    logic            w_found;
    logic [PW:0]     w_nvalid;
    logic [r-1:0]    w_addr;
    logic [n-1:0]    w_data;
    logic            w_xfer;

    // Scan starts one past the last winner so the previous winner has lowest priority.
    always_comb begin
        w_grant    = '0;
        w_gidx     = '0;
        w_scan_idx = '0;
        w_found    = 1'b0;
        if (rst_n && !hold) begin
            for (int k = 1; k <= int'(NREQ); k++) begin
                w_scan_idx = PW'((int'(r_ptr) + k) % int'(NREQ));
                if (!w_found && req_valid[w_scan_idx]) begin
                    w_grant[w_scan_idx] = 1'b1;
                    w_gidx              = w_scan_idx;
                    w_found             = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_nvalid = '0;
        w_addr   = '0;
        w_data   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            w_nvalid = w_nvalid + (PW+1)'(req_valid[i]);
            if (w_grant[i]) begin
                w_addr = req_addr[i*r +: r];
                w_data = req_data[i*n +: n];
            end
        end
    end

    assign req_ready = w_grant;
    assign w_xfer    = |(req_valid & w_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PW'(NREQ - 1);
            r_we3 <= 1'b0;
            r_wa3 <= '0;
            r_wd3 <= '0;
            r_cnt <= '0;
        end else begin
            r_we3 <= 1'b0;
            if (w_xfer) begin
                r_ptr <= w_gidx;
                r_wa3 <= w_addr;
                r_wd3 <= w_data;
                // x0 writes are consumed but never reach the register file
                r_we3 <= (w_addr != '0);
            end
            if (!hold && (w_nvalid >= (PW+1)'(2)) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign we3          = r_we3;
    assign wa3          = r_wa3;
    assign wd3          = r_wd3;
    assign conflict_cnt = r_cnt;

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the in-flight write during the cycle before the register file commits it.
    assign rd1 = (r_we3 && (r_wa3 == ra1) && (ra1 != '0)) ? r_wd3 : rf_rd1;
    assign rd2 = (r_we3 && (r_wa3 == ra2) && (ra2 != '0)) ? r_wd3 : rf_rd2;
`else
    logic w_unused_ra;
    assign w_unused_ra = ^{ra1, ra2};
    assign rd1         = rf_rd1;
    assign rd2         = rf_rd2;
`endif

endmodule
